instr_encoder: RTL and testbench

//  Packs decoded RV64IM instruction fields (opcode, func3, func7, rd, rs1, rs2, immediate, shamt) into a 32-bit instruction word.

---
 rtl/instr_encoder.sv | 275 +++++++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Packs decoded RV64IM instruction fields into a 32-bit instruction word.
//   Field names and widths mirror the decoder outputs so that encode->decode
//   round trips can be compared directly. Two-stage valid/ready pipeline:
//   stage 1 classifies the format and checks immediate range / alignment /
//   shift amount, stage 2 packs the word (or substitutes NOP_WORD on error).
//
// Parameters
//   NOP_WORD     word emitted in place of any instruction that fails a check
//   ERR_CNT_W    width of the saturating error counter
//
// Ports
//   clk           clock
//   reset         synchronous, active-high reset (drops words in flight)
//   in_valid      input fields valid
//   in_ready      encoder can accept the input this cycle (combinational)
//   opcode        RV opcode, selects the format
//   func3/func7   function fields
//   rd/rs1/rs2    register specifiers
//   immediate     sign-extended byte immediate (decoder convention)
//   shamt         shift amount for shift-immediate instructions
//   out_valid     out_instr is valid
//   out_ready     downstream accepts out_instr
//   out_instr     encoded instruction word
//   out_err       out_instr is NOP_WORD because a check failed
//   out_err_code  0 none, 1 illegal opcode, 2 imm out of range,
//                 3 misaligned, 4 bad shamt
//   enc_count     words accepted at the output (wraps)
//   err_count     words accepted with out_err=1 (saturates at all-ones)
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter logic [31:0] NOP_WORD  = 32'h00000013,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [2:0]           func3,
  input  logic [6:0]           func7,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [31:0]          immediate,
  input  logic [5:0]           shamt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [2:0]           out_err_code,
  output logic [31:0]          enc_count,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [3:0] {
    FMT_R,
    FMT_I,
    FMT_SHI,   // 64-bit shift-immediate: 6-bit shamt, func7[6:1]
    FMT_SHIW,  // 32-bit shift-immediate: 5-bit shamt, full func7
    FMT_S,
    FMT_SB,
    FMT_U,
    FMT_UJ,
    FMT_BAD
  } fmt_e;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_OPCODE = 3'd1,
    ERR_RANGE  = 3'd2,
    ERR_ALIGN  = 3'd3,
    ERR_SHAMT  = 3'd4
  } err_e;

  // Pipeline control
  logic s1_valid;
  logic s2_valid;
  logic s1_advance;

  // Stage 1 registers
  fmt_e        s1_fmt;
  err_e        s1_err;
  logic [6:0]  s1_opcode;
  logic [2:0]  s1_func3;
  logic [6:0]  s1_func7;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [31:0] s1_imm;
  logic [5:0]  s1_shamt;

  // Combinational classification of the incoming fields
  fmt_e in_fmt;
  err_e in_err;
  logic range_bad;
  logic align_bad;
  logic shamt_bad;
  logic imm_fits_12;
  logic imm_fits_13;
  logic imm_fits_21;
  logic is_shift_f3;

  // Packed word built from stage 1 registers
  logic [31:0] pack_word;

  // Stage 2 may take a new word when it is empty or its word leaves now;
  // stage 1 may take a new input when it is empty or its word moves on.
  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign out_valid  = s2_valid;

  // Sign-extension checks: all bits above the field's sign bit must match it.
  assign imm_fits_12 = (&immediate[31:11]) || !(|immediate[31:11]);
  assign imm_fits_13 = (&immediate[31:12]) || !(|immediate[31:12]);
  assign imm_fits_21 = (&immediate[31:20]) || !(|immediate[31:20]);
  assign is_shift_f3 = (func3 == 3'b001) || (func3 == 3'b101);

  // Format selection and the individual check results for the input fields.
  // Shift-immediates share opcodes with ordinary I-type ALU ops and are told
  // apart by func3; they carry a shift amount instead of an immediate, so
  // the immediate range rule does not apply to them.
  always_comb begin
    in_fmt    = FMT_BAD;
    range_bad = 1'b0;
    align_bad = 1'b0;
    shamt_bad = 1'b0;
    case (opcode)
      7'b0110011, 7'b0111011: begin
        in_fmt = FMT_R;
      end
      7'b0010011: begin
        if (is_shift_f3) begin
          in_fmt = FMT_SHI;
        end else begin
          in_fmt    = FMT_I;
          range_bad = !imm_fits_12;
        end
      end
      7'b0011011: begin
        if (is_shift_f3) begin
          in_fmt    = FMT_SHIW;
          shamt_bad = shamt[5];
        end else begin
          in_fmt    = FMT_I;
          range_bad = !imm_fits_12;
        end
      end
      7'b0000011, 7'b1100111: begin
        in_fmt    = FMT_I;
        range_bad = !imm_fits_12;
      end
      7'b0100011: begin
        in_fmt    = FMT_S;
        range_bad = !imm_fits_12;
      end
      7'b1100011: begin
        in_fmt    = FMT_SB;
        range_bad = !imm_fits_13;
        align_bad = immediate[0];
      end
      7'b0110111, 7'b0010111: begin
        in_fmt    = FMT_U;
        range_bad = (immediate[11:0] != 12'd0);
      end
      7'b1101111: begin
        in_fmt    = FMT_UJ;
        range_bad = !imm_fits_21;
        align_bad = immediate[0];
      end
      default: begin
        in_fmt = FMT_BAD;
      end
    endcase
  end

  // Error priority: illegal opcode, then misalignment, then range, then shamt.
  // A branch that is both odd and out of range reports misalignment.
  always_comb begin
    in_err = ERR_NONE;
    if (in_fmt == FMT_BAD) begin
      in_err = ERR_OPCODE;
    end else if (align_bad) begin
      in_err = ERR_ALIGN;
    end else if (range_bad) begin
      in_err = ERR_RANGE;
    end else if (shamt_bad) begin
      in_err = ERR_SHAMT;
    end
  end

  // Stage 1: capture the classification and all raw fields on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_fmt    <= FMT_BAD;
      s1_err    <= ERR_NONE;
      s1_opcode <= 7'd0;
      s1_func3  <= 3'd0;
      s1_func7  <= 7'd0;
      s1_rd     <= 5'd0;
      s1_rs1    <= 5'd0;
      s1_rs2    <= 5'd0;
      s1_imm    <= 32'd0;
      s1_shamt  <= 6'd0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fmt    <= in_fmt;
        s1_err    <= in_err;
        s1_opcode <= opcode;
        s1_func3  <= func3;
        s1_func7  <= func7;
        s1_rd     <= rd;
        s1_rs1    <= rs1;
        s1_rs2    <= rs2;
        s1_imm    <= immediate;
        s1_shamt  <= shamt;
      end
    end
  end

  // Bit packing per format. Branch and jump offsets drop bit 0 because
  // targets are always even; the scattered bit order matches the ISA.
  always_comb begin
    pack_word = NOP_WORD;
    case (s1_fmt)
      FMT_R:    pack_word = {s1_func7, s1_rs2, s1_rs1, s1_func3, s1_rd, s1_opcode};
      FMT_I:    pack_word = {s1_imm[11:0], s1_rs1, s1_func3, s1_rd, s1_opcode};
      FMT_SHI:  pack_word = {s1_func7[6:1], s1_shamt, s1_rs1, s1_func3, s1_rd, s1_opcode};
      FMT_SHIW: pack_word = {s1_func7, s1_shamt[4:0], s1_rs1, s1_func3, s1_rd, s1_opcode};
      FMT_S:    pack_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_func3, s1_imm[4:0], s1_opcode};
      FMT_SB:   pack_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_func3,
                             s1_imm[4:1], s1_imm[11], s1_opcode};
      FMT_U:    pack_word = {s1_imm[31:12], s1_rd, s1_opcode};
      FMT_UJ:   pack_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                             s1_rd, s1_opcode};
      default:  pack_word = NOP_WORD;
    endcase
  end

  // Stage 2: the output register. It only moves when the downstream side
  // takes the current word (or holds none), which keeps the outputs stable
  // under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid     <= 1'b0;
      out_instr    <= 32'd0;
      out_err      <= 1'b0;
      out_err_code <= 3'd0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_instr    <= (s1_err != ERR_NONE) ? NOP_WORD : pack_word;
        out_err      <= (s1_err != ERR_NONE);
        out_err_code <= s1_err;
      end
    end
  end

  // Output statistics, counted on the output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_count <= 32'd0;
      err_count <= '0;
    end else if (s2_valid && out_ready) begin
      enc_count <= enc_count + 32'd1;
      if (out_err && (err_count != {ERR_CNT_W{1'b1}})) begin
        err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//   Directed testbench for instr_encoder. Each test task drives its own
//   vectors and compares against hand-computed instruction words.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] immediate;
  logic [5:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [2:0]  out_err_code;
  logic [31:0] enc_count;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;
  int exp_enc = 0;
  int exp_err = 0;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [5:0]  sh;
    logic [31:0] word;
    logic [2:0]  code;
  } vec_t;

  instr_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .func3        (func3),
    .func7        (func7),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .immediate    (immediate),
    .shamt        (shamt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_err      (out_err),
    .out_err_code (out_err_code),
    .enc_count    (enc_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] r_d,
                              input logic [4:0] r_s1, input logic [4:0] r_s2,
                              input logic [31:0] imm, input logic [5:0] sh,
                              input logic [31:0] word, input logic [2:0] code);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.rd = r_d; v.rs1 = r_s1; v.rs2 = r_s2;
    v.imm = imm; v.sh = sh; v.word = word; v.code = code;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    opcode    = v.op;
    func3     = v.f3;
    func7     = v.f7;
    rd        = v.rd;
    rs1       = v.rs1;
    rs2       = v.rs2;
    immediate = v.imm;
    shamt     = v.sh;
  endtask

  // Sends one instruction into an empty pipeline with out_ready high and
  // returns what came out plus the number of posedges from accept to
  // out_valid (accept edge included). lat = -1 means nothing came out.
  task automatic run_single(input vec_t v, output logic [31:0] w,
                            output logic e, output logic [2:0] c,
                            output int lat);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    w = out_instr;
    e = out_err;
    c = out_err_code;
    if (out_valid) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(mk(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 6'd0, 32'd0, 3'd0));
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (out_instr !== 32'd0) begin bad++; $display("[TB] FAIL reset_out_instr got=%h want=00000000", out_instr); end
    total++; if (out_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_err got=%0b want=0", out_err); end
    total++; if (out_err_code !== 3'd0) begin bad++; $display("[TB] FAIL reset_err_code got=%0d want=0", out_err_code); end
    total++; if (enc_count !== 32'd0) begin bad++; $display("[TB] FAIL reset_enc_count got=%0d want=0", enc_count); end
    total++; if (err_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_err_count got=%0d want=0", err_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%0b want=1", in_ready); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_formats();
    vec_t v[10];
    logic [31:0] w;
    logic e;
    logic [2:0] c;
    int lat;
    v[0] = mk(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        6'd0,  32'h002081B3, 3'd0); // add x3,x1,x2
    v[1] = mk(7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 6'd0,  32'hFFF00293, 3'd0); // addi x5,x0,-1
    v[2] = mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        6'd0,  32'h00208463, 3'd0); // beq x1,x2,8
    v[3] = mk(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,     6'd0,  32'h001000EF, 3'd0); // jal x1,2048
    v[4] = mk(7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd0,        6'd63, 32'h03F09093, 3'd0); // slli x1,x1,63
    v[5] = mk(7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd0,        6'd63, 32'h43F0D093, 3'd0); // srai x1,x1,63
    v[6] = mk(7'h1B, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd0,        6'd31, 32'h01F0909B, 3'd0); // slliw x1,x1,31
    v[7] = mk(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 6'd0,  32'h123452B7, 3'd0); // lui x5,0x12345
    v[8] = mk(7'h23, 3'd3, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        6'd0,  32'h0020B423, 3'd0); // sd x2,8(x1)
    v[9] = mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 6'd0,  32'hFE000EE3, 3'd0); // beq x0,x0,-4
    for (int i = 0; i < 10; i++) begin
      run_single(v[i], w, e, c, lat);
      exp_enc++;
      total++; if (lat !== 2) begin bad++; $display("[TB] FAIL fmt%0d_latency got=%0d want=2", i, lat); end
      total++; if (w !== v[i].word) begin bad++; $display("[TB] FAIL fmt%0d_word got=%h want=%h", i, w, v[i].word); end
      total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL fmt%0d_err got=%0b want=0", i, e); end
      total++; if (c !== v[i].code) begin bad++; $display("[TB] FAIL fmt%0d_code got=%0d want=%0d", i, c, v[i].code); end
    end
    total++; if (enc_count !== 32'(exp_enc)) begin bad++; $display("[TB] FAIL fmt_enc_count got=%0d want=%0d", enc_count, exp_enc); end
    total++; if (err_count !== 16'(exp_err)) begin bad++; $display("[TB] FAIL fmt_err_count got=%0d want=%0d", err_count, exp_err); end
  endtask

  task automatic test_errors();
    vec_t v[7];
    logic [31:0] w;
    logic e;
    logic [2:0] c;
    int lat;
    v[0] = mk(7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'd2048,     6'd0,  32'h00000013, 3'd2); // addi imm too big
    v[1] = mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3,        6'd0,  32'h00000013, 3'd3); // beq odd offset
    v[2] = mk(7'h1B, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd0,        6'd32, 32'h00000013, 3'd4); // slliw shamt 32
    v[3] = mk(7'h7F, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd0,        6'd0,  32'h00000013, 3'd1); // illegal opcode
    v[4] = mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h00001001, 6'd0,  32'h00000013, 3'd3); // odd and far: align wins
    v[5] = mk(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345001, 6'd0,  32'h00000013, 3'd2); // lui low bits set
    v[6] = mk(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00100000, 6'd0,  32'h00000013, 3'd2); // jal beyond 1 MiB
    for (int i = 0; i < 7; i++) begin
      run_single(v[i], w, e, c, lat);
      exp_enc++;
      exp_err++;
      total++; if (lat !== 2) begin bad++; $display("[TB] FAIL err%0d_latency got=%0d want=2", i, lat); end
      total++; if (w !== v[i].word) begin bad++; $display("[TB] FAIL err%0d_word got=%h want=%h", i, w, v[i].word); end
      total++; if (e !== 1'b1) begin bad++; $display("[TB] FAIL err%0d_err got=%0b want=1", i, e); end
      total++; if (c !== v[i].code) begin bad++; $display("[TB] FAIL err%0d_code got=%0d want=%0d", i, c, v[i].code); end
      total++; if (err_count !== 16'(exp_err)) begin bad++; $display("[TB] FAIL err%0d_err_count got=%0d want=%0d", i, err_count, exp_err); end
    end
    total++; if (enc_count !== 32'(exp_enc)) begin bad++; $display("[TB] FAIL err_enc_count got=%0d want=%0d", enc_count, exp_enc); end
  endtask

  // Six addi words, out_ready low during loop cycles 2..5.
  task automatic test_back_to_back();
    logic [31:0] exp_word [6];
    logic [31:0] prev_word;
    logic        prev_stall;
    logic        saw_full;
    logic        exp_ir;
    logic        take_in;
    logic        take_out;
    int sent;
    int recv;
    for (int i = 0; i < 6; i++) begin
      logic [11:0] imm12;
      imm12 = 12'(i * 16 + 1);
      exp_word[i] = {imm12, 5'd0, 3'd0, 5'(i + 1), 7'h13};
    end
    sent = 0;
    recv = 0;
    prev_stall = 1'b0;
    prev_word  = 32'd0;
    saw_full   = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (sent == 6 && recv == 6) break;
      out_ready = !(cyc >= 2 && cyc <= 5);
      if (sent < 6) begin
        drive(mk(7'h13, 3'd0, 7'h00, 5'(sent + 1), 5'd0, 5'd0, 32'(sent * 16 + 1),
                 6'd0, 32'd0, 3'd0));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      // Two stages: the encoder is only full when holding two words.
      exp_ir = !((sent - recv) == 2 && !out_ready);
      total++; if (in_ready !== exp_ir) begin bad++; $display("[TB] FAIL b2b_in_ready cyc=%0d got=%0b want=%0b", cyc, in_ready, exp_ir); end
      if (in_ready === 1'b0) saw_full = 1'b1;
      if (prev_stall) begin
        total++; if (out_valid !== 1'b1 || out_instr !== prev_word) begin bad++; $display("[TB] FAIL b2b_stable cyc=%0d got=%h want=%h", cyc, out_instr, prev_word); end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = out_instr;
      take_out = out_valid && out_ready;
      take_in  = in_valid && in_ready;
      if (take_out) begin
        total++; if (recv >= 6 || out_instr !== exp_word[recv % 6]) begin bad++; $display("[TB] FAIL b2b_word idx=%0d got=%h want=%h", recv, out_instr, exp_word[recv % 6]); end
      end
      @(posedge clk);
      #1;
      if (take_out) recv++;
      if (take_in) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp_enc += 6;
    total++; if (recv !== 6 || sent !== 6) begin bad++; $display("[TB] FAIL b2b_complete got=sent %0d recv %0d want=6 6", sent, recv); end
    total++; if (saw_full !== 1'b1) begin bad++; $display("[TB] FAIL b2b_backpressure got=%0b want=1", saw_full); end
    total++; if (enc_count !== 32'(exp_enc)) begin bad++; $display("[TB] FAIL b2b_enc_count got=%0d want=%0d", enc_count, exp_enc); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] w;
    logic e;
    logic [2:0] c;
    int lat;
    out_ready = 1'b0;
    drive(mk(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 6'd0, 32'd0, 3'd0));
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_full got=%0b%0b want=10", out_valid, in_ready); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    exp_enc = 0;
    exp_err = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_out_valid got=%0b want=0", out_valid); end
    total++; if (enc_count !== 32'd0) begin bad++; $display("[TB] FAIL mid_enc_count got=%0d want=0", enc_count); end
    total++; if (err_count !== 16'd0) begin bad++; $display("[TB] FAIL mid_err_count got=%0d want=0", err_count); end
    total++; if (out_instr !== 32'd0) begin bad++; $display("[TB] FAIL mid_out_instr got=%h want=00000000", out_instr); end
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_no_ghost got=%0b want=0", out_valid); end
    run_single(mk(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 6'd0, 32'd0, 3'd0), w, e, c, lat);
    exp_enc++;
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL mid_latency got=%0d want=2", lat); end
    total++; if (w !== 32'h002081B3) begin bad++; $display("[TB] FAIL mid_word got=%h want=002081B3", w); end
    total++; if (enc_count !== 32'(exp_enc)) begin bad++; $display("[TB] FAIL mid_enc_after got=%0d want=%0d", enc_count, exp_enc); end
  endtask

  initial begin
    $display("[TB] instr_encoder directed tests starting");
    test_reset();
    test_formats();
    test_errors();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
